vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync-pulse pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync-pulse lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back-porch lines.
REQ-009 SHALL have parameter HS_POL, default 0, asserted level of hsync.
REQ-010 SHALL have parameter VS_POL, default 0, asserted level of vsync.
REQ-011 SHALL have parameter CNT_W, default 10, counter output width.
REQ-012 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-013 SHALL have ports: rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-014 SHALL have ports: pix_en  in  1  pixel-rate clock enable.
REQ-015 SHALL have ports: hCount  out  CNT_W  current pixel column; vCount  out  CNT_W  current line.
REQ-016 SHALL have ports: hsync, vsync  out  1  sync outputs at HS_POL/VS_POL when asserted.
REQ-017 SHALL have ports: de  out  1  display enable; end_of_line, end_of_frame  out  1  last-pixel flags.

Function
REQ-018 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise; hCount period SHALL be exactly H_TOTAL pix_en cycles (0..H_TOTAL-1).
REQ-019 SHALL advance state only on clk edges with pix_en=1; with pix_en=0 all outputs hold.
REQ-020 SHALL increment hCount per pix_en; at H_TOTAL-1 it wraps to 0 and vCount increments; at vCount=V_TOTAL-1 with hCount wrap, vCount wraps to 0.
REQ-021 SHALL register all outputs; hCount, vCount, hsync, vsync, de, end flags SHALL always describe the same pixel position (no skew).
REQ-022 SHALL assert hsync when H_VISIBLE+H_FRONT <= hCount < H_VISIBLE+H_FRONT+H_SYNC, else drive ~HS_POL.
REQ-023 SHALL assert vsync when V_VISIBLE+V_FRONT <= vCount < V_VISIBLE+V_FRONT+V_SYNC, for whole lines, else ~VS_POL.
REQ-024 SHALL drive de=1 iff hCount<H_VISIBLE and vCount<V_VISIBLE and position valid.
REQ-025 SHALL drive end_of_line=1 iff hCount=H_TOTAL-1; end_of_frame=1 iff additionally vCount=V_TOTAL-1.
REQ-026 SHALL, on the first pix_en after reset release, present position (0,0) (de=1); the idle state between reset and that cycle is not a valid position.
REQ-027 SHALL fail elaboration if CNT_W cannot hold H_TOTAL-1 or V_TOTAL-1, or if any H_*/V_* parameter is 0.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, regardless of pix_en: hCount=0, vCount=0, de=0, end_of_line=0, end_of_frame=0, hsync=~HS_POL, vsync=~VS_POL, position invalid.
REQ-029 SHALL abort any line/frame on reset mid-operation; no partial sync pulse continues past reset.

Structure
REQ-030 SHALL place default 640x480@60 timing constants and a total-computation function in shared package vga_timing_pkg.
REQ-031 SHALL implement each axis with one sub-module timing_axis (parametrised wrap counter with tick-in, wrap-out, sync and visible decode), instantiated twice.

Verification (bench parameters H=8/2/2/2 (H_TOTAL=14), V=4/1/1/1 (V_TOTAL=7), CNT_W=4, pol=0)
REQ-032 SHALL cover: reset, then pix_en=1 continuous -> first valid cycle hCount=0,vCount=0,de=1; hCount 13->0 with vCount 0->1; end_of_line high only at hCount=13.
REQ-033 SHALL cover: full frame -> hsync=0 exactly at hCount 10..11; vsync=0 exactly for all pixels of vCount 5; de=1 for 32 pixels per frame; end_of_frame once per 98 pix_en cycles at (13,6).
REQ-034 SHALL cover: pix_en toggling 1,0,0,1 -> outputs hold across the two 0 cycles and advance by exactly one position after.
REQ-035 SHALL cover: rst_n=0 for one cycle at (11,5) -> next cycle hCount=0,vCount=0,hsync=1,vsync=1,de=0; resumes at (0,0) on next pix_en.
REQ-036 SHALL cover: HS_POL=1,VS_POL=1 rerun of REQ-033 -> sync levels inverted, timing identical; CNT_W=3 with H_TOTAL=14 -> elaboration error.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Default 640x480@60 timing constants and per-axis total helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CNT_W     = 10;

  function automatic int axis_total(input int vis, input int front,
                                    input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  function automatic bit fits_width(input int value, input int width);
    return (width >= 31) || (value < (1 << width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Pixel-enable input and raster position/sync outputs bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             pix_en;
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             end_of_line;
  logic             end_of_frame;

  modport master (
    input  pix_en,
    output hCount, vCount, hsync, vsync, de, end_of_line, end_of_frame
  );

  modport slave (
    output pix_en,
    input  hCount, vCount, hsync, vsync, de, end_of_line, end_of_frame
  );
endinterface

`default_nettype wire

// File: rtl/timing_axis.sv
// ============================================================================
// Module   : timing_axis
// Purpose  : One raster axis: wrap counter with registered sync and next-state
//            visible/last decode for the parent to register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter bit POL     = 1'b0,
  parameter int CNT_W   = 10
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_tick,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_sync,
  output logic                  o_vis_nxt,
  output logic                  o_last_nxt
);

  localparam int               TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_VIS      = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] C_SYNC_LO  = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] C_SYNC_HI  = CNT_W'(VISIBLE + FRONT + SYNC);

  logic [CNT_W-1:0] r_count;
  logic             r_sync;
  logic [CNT_W-1:0] w_nxt;
  logic             w_sync_nxt;

  always_comb begin
    w_nxt = r_count;
    if (i_tick) begin
      w_nxt = (r_count == C_LAST) ? '0 : r_count + CNT_W'(1);
    end
  end

  // Decode from the next count so registered sync lines up with the count.
  assign w_sync_nxt = (w_nxt >= C_SYNC_LO) && (w_nxt < C_SYNC_HI);
  assign o_vis_nxt  = (w_nxt < C_VIS);
  assign o_last_nxt = (w_nxt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sync  <= ~POL;
    end else begin
      r_count <= w_nxt;
      r_sync  <= w_sync_nxt ? POL : ~POL;
    end
  end

  assign o_count = r_count;
  assign o_sync  = r_sync;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parameterised VGA raster timing generator with pixel enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_zero
    $error("vga_timing_gen: every H_*/V_* timing parameter must be non-zero");
  end

  if (!fits_width(H_TOTAL - 1, CNT_W) || !fits_width(V_TOTAL - 1, CNT_W)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
  end

  logic             r_valid;
  logic             r_de;
  logic             r_eol;
  logic             r_eof;
  logic [CNT_W-1:0] w_h_count;
  logic [CNT_W-1:0] w_v_count;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_h_vis_nxt;
  logic             w_v_vis_nxt;
  logic             w_h_last_nxt;
  logic             w_v_last_nxt;
  logic             w_tick_h;
  logic             w_tick_v;
  logic             w_live;

  // The first enable after reset only validates (0,0); counting starts after.
  assign w_tick_h = bus.pix_en & r_valid;
  assign w_tick_v = w_tick_h & r_eol;
  assign w_live   = r_valid | bus.pix_en;

  timing_axis #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_tick_h),
    .o_count   (w_h_count),
    .o_sync    (w_hsync),
    .o_vis_nxt (w_h_vis_nxt),
    .o_last_nxt(w_h_last_nxt)
  );

  timing_axis #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_tick_v),
    .o_count   (w_v_count),
    .o_sync    (w_vsync),
    .o_vis_nxt (w_v_vis_nxt),
    .o_last_nxt(w_v_last_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_de    <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      if (bus.pix_en) begin
        r_valid <= 1'b1;
      end
      r_de  <= w_h_vis_nxt & w_v_vis_nxt & w_live;
      r_eol <= w_h_last_nxt & w_live;
      r_eof <= w_h_last_nxt & w_v_last_nxt & w_live;
    end
  end

  assign bus.hCount       = w_h_count;
  assign bus.vCount       = w_v_count;
  assign bus.hsync        = w_hsync;
  assign bus.vsync        = w_vsync;
  assign bus.de           = r_de;
  assign bus.end_of_line  = r_eol;
  assign bus.end_of_frame = r_eof;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen at both sync polarities.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hs;
    logic          vs;
    logic          de;
    logic          eol;
    logic          eof;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(CW)) bus0 ();
  vga_timing_gen_if #(.CNT_W(CW)) bus1 ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  obs_t q0[$];
  obs_t q1[$];
  int   errors = 0;
  int   checks = 0;

  // Reference raster position: plain integer coordinates plus a valid flag.
  int   hp = 0;
  int   vp = 0;
  bit   valid = 1'b0;

  int   de_tot = 0, eof_tot = 0, eol_tot = 0;
  int   hs0_tot = 0, vs0_tot = 0, hs1_tot = 0, vs1_tot = 0;

  function automatic obs_t expect_at(input bit pol);
    obs_t e;
    bit   hs_on;
    bit   vs_on;
    hs_on = (hp >= HV + HF) && (hp < HV + HF + HS);
    vs_on = (vp >= VV + VF) && (vp < VV + VF + VS);
    e.h   = CW'(hp);
    e.v   = CW'(vp);
    e.hs  = hs_on ? pol : ~pol;
    e.vs  = vs_on ? pol : ~pol;
    e.de  = valid && (hp < HV) && (vp < VV);
    e.eol = valid && (hp == HT - 1);
    e.eof = valid && (hp == HT - 1) && (vp == VT - 1);
    return e;
  endfunction

  task automatic step(input bit r, input bit pe);
    @(negedge clk);
    rst_n       = r;
    bus0.pix_en = pe;
    bus1.pix_en = pe;
    if (!r) begin
      hp = 0; vp = 0; valid = 1'b0;
    end else if (pe) begin
      if (!valid) begin
        valid = 1'b1;
      end else begin
        hp++;
        if (hp == HT) begin
          hp = 0;
          vp++;
          if (vp == VT) vp = 0;
        end
      end
    end
    q0.push_back(expect_at(1'b0));
    q1.push_back(expect_at(1'b1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic compare(input string name, input obs_t g, input obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b de=%b eol=%b eof=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b eol=%b eof=%b",
               name, g.h, g.v, g.hs, g.vs, g.de, g.eol, g.eof,
               e.h, e.v, e.hs, e.vs, e.de, e.eol, e.eof);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor_loop();
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        g = {bus0.hCount, bus0.vCount, bus0.hsync, bus0.vsync,
             bus0.de, bus0.end_of_line, bus0.end_of_frame};
        compare("pos_pol0", g, q0.pop_front());
        de_tot  += int'(bus0.de);
        eol_tot += int'(bus0.end_of_line);
        eof_tot += int'(bus0.end_of_frame);
        hs0_tot += int'(bus0.hsync == 1'b0);
        vs0_tot += int'(bus0.vsync == 1'b0);
      end
      if (q1.size() > 0) begin
        g = {bus1.hCount, bus1.vCount, bus1.hsync, bus1.vsync,
             bus1.de, bus1.end_of_line, bus1.end_of_frame};
        compare("pos_pol1", g, q1.pop_front());
        hs1_tot += int'(bus1.hsync == 1'b1);
        vs1_tot += int'(bus1.vsync == 1'b1);
      end
    end
  endtask

  task automatic stimulus();
    int s_de, s_eol, s_eof, s_hs0, s_vs0, s_hs1, s_vs1;
    bit reached;

    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    settle();
    s_de = de_tot; s_eol = eol_tot; s_eof = eof_tot;
    s_hs0 = hs0_tot; s_vs0 = vs0_tot; s_hs1 = hs1_tot; s_vs1 = vs1_tot;

    // One complete frame of continuous enables starting from (0,0).
    for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b1);
    settle();
    check_int("frame_de_count",  de_tot  - s_de,  HV * VV);
    check_int("frame_eol_count", eol_tot - s_eol, VT);
    check_int("frame_eof_count", eof_tot - s_eof, 1);
    check_int("frame_hsync_low_pol0",  hs0_tot - s_hs0, HS * VT);
    check_int("frame_vsync_low_pol0",  vs0_tot - s_vs0, VS * HT);
    check_int("frame_hsync_high_pol1", hs1_tot - s_hs1, HS * VT);
    check_int("frame_vsync_high_pol1", vs1_tot - s_vs1, VS * HT);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
    end

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0));
    end

    // Drive to (11,5) and pulse reset for a single cycle.
    reached = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !reached; i++) begin
      step(1'b1, 1'b1);
      reached = valid && (hp == 11) && (vp == 5);
    end
    check_int("reach_11_5", int'(reached), 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) != 0));
    end
    settle();
    check_int("scoreboard_drained_pol0", q0.size(), 0);
    check_int("scoreboard_drained_pol1", q1.size(), 0);
  endtask

  initial begin
    bus0.pix_en = 1'b0;
    bus1.pix_en = 1'b0;
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
